// File: rtl/led_pkg.sv
// led_pkg: shared constants, FSM states and helpers for the LED RAM
// arbiter and the matrix scanner.
package led_pkg;

  localparam int ROWS = 8;
  localparam int COLS = 8;
  localparam int DW   = 4;

  localparam logic GRANT_R = 1'b0;
  localparam logic GRANT_W = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    W_HI,
    W_LO,
    W_ACK,
    R_ADDR,
    R_ACK,
    CLR
  } arb_state_t;

  function automatic logic [7:0] bin_to_onehot(
    input logic [2:0] b
  );
    logic [7:0] oh;
    oh    = '0;
    oh[b] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/led_rr_pick.sv
// led_rr_pick: combinational 2-way picker, write vs read.
// rr_en=1 alternates on contention using last_grant; else write wins.
module led_rr_pick
  import led_pkg::*;
(
  input  logic req_w,
  input  logic req_r,
  input  logic last_grant,
  input  logic rr_en,
  output logic grant_w,
  output logic grant_r
);

  assign grant_w = req_w &
    (~req_r | ~rr_en | (last_grant == GRANT_R));
  assign grant_r = req_r & ~grant_w;

endmodule

// File: rtl/led_ram_arbiter.sv
// led_ram_arbiter: shares the one-hot LED RAM port between pen writes
// (wr_*) and scan reads (rd_*); drives ram_* and aborts on state toggles.
module led_ram_arbiter
  import led_pkg::*;
#(
  parameter bit ARB_RR = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            state,
  input  logic            wr_req,
  input  logic [2:0]      wr_row,
  input  logic [2:0]      wr_col,
  input  logic [DW-1:0]   wr_data,
  output logic            wr_ack,
  output logic            wr_err,
  input  logic            rd_req,
  input  logic [2:0]      rd_row,
  input  logic [2:0]      rd_col,
  output logic            rd_valid,
  output logic [DW-1:0]   rd_data,
  output logic [ROWS-1:0] ram_addr_row,
  output logic [COLS-1:0] ram_addr_col,
  output logic [DW-1:0]   ram_data,
  output logic            ram_we,
  input  logic [DW-1:0]   ram_led_data
);

  arb_state_t fsm;
  logic       last_grant;
  logic       state_d;
  logic       clr_pend;
  logic       toggle;
  logic       grant_w;
  logic       grant_r;

  assign toggle = state ^ state_d;

  led_rr_pick u_pick (
    .req_w      (wr_req),
    .req_r      (rd_req),
    .last_grant (last_grant),
    .rr_en      (ARB_RR),
    .grant_w    (grant_w),
    .grant_r    (grant_r)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm          <= IDLE;
      last_grant   <= GRANT_R;
      state_d      <= 1'b0;
      clr_pend     <= 1'b0;
      ram_addr_row <= 8'h01;
      ram_addr_col <= 8'h01;
      ram_data     <= '0;
      ram_we       <= 1'b0;
      wr_ack       <= 1'b0;
      wr_err       <= 1'b0;
      rd_valid     <= 1'b0;
      rd_data      <= '0;
    end else begin
      state_d  <= state;
      ram_we   <= 1'b0;
      wr_ack   <= 1'b0;
      wr_err   <= 1'b0;
      rd_valid <= 1'b0;
      unique case (fsm)
        // CLR is the RAM clear cycle: nothing is granted during it, and the
        // request sampled at its end goes straight to the arbiter.
        IDLE, CLR: begin
          if (toggle) begin
            fsm <= CLR;
          end else if (grant_w) begin
            fsm          <= W_HI;
            last_grant   <= GRANT_W;
            ram_we       <= 1'b1;
            ram_addr_row <= bin_to_onehot(wr_row);
            ram_addr_col <= bin_to_onehot(wr_col);
            ram_data     <= wr_data;
          end else if (grant_r) begin
            fsm          <= R_ADDR;
            last_grant   <= GRANT_R;
            ram_addr_row <= bin_to_onehot(rd_row);
            ram_addr_col <= bin_to_onehot(rd_col);
          end else begin
            fsm <= IDLE;
          end
        end
        W_HI, W_LO: begin
          fsm    <= W_ACK;
          wr_ack <= (fsm == W_LO) | toggle;
          wr_err <= toggle;
          if (toggle) begin
            clr_pend <= 1'b1;
          end else if (fsm == W_HI) begin
            fsm    <= W_LO;
            wr_ack <= 1'b0;
          end
        end
        R_ADDR: begin
          fsm      <= R_ACK;
          rd_valid <= 1'b1;
          rd_data  <= ram_led_data;
          if (toggle) clr_pend <= 1'b1;
        end
        W_ACK, R_ACK: begin
          fsm      <= (toggle | clr_pend) ? CLR : IDLE;
          clr_pend <= 1'b0;
        end
        default: fsm <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/led_ram_arbiter.md
Name: led_ram_arbiter

Overview:
Shares the single one-hot address port of the 8x8x4 LED display RAM between two requesters: the light-pen write path and the display scan read path.
Generates the RAM write protocol: a one-cycle we high pulse that latches the address and data, then we low, which commits the write.
Tracks the mode `state` input and aborts or blocks traffic while the RAM clears itself on a mode change.
Sits between the pen/touch logic, the matrix scanner and the display RAM.

Parameters:
ARB_RR, 1, 1 = round-robin between write and read on contention; 0 = write always wins.
ROWS, 8, matrix rows (one-hot address width); fixed at 8 for this revision.
COLS, 8, matrix columns (one-hot address width); fixed at 8.
DW, 4, pixel data width.

Ports:
clk  in  1  system clock; single clock domain.
rst_n  in  1  asynchronous active-low reset.
state  in  1  display mode; any toggle clears the RAM.
wr_req  in  1  write request, level; hold until wr_ack.
wr_row  in  3  binary row; stable while wr_req.
wr_col  in  3  binary column; stable while wr_req.
wr_data  in  DW  pixel value; stable while wr_req.
wr_ack  out  1  one-cycle pulse, write finished or aborted.
wr_err  out  1  valid with wr_ack; 1 = aborted by a state toggle.
rd_req  in  1  read request, level; hold until rd_valid.
rd_row  in  3  binary row.
rd_col  in  3  binary column.
rd_valid  out  1  one-cycle pulse, rd_data valid.
rd_data  out  DW  registered pixel value.
ram_addr_row  out  ROWS  one-hot row to RAM.
ram_addr_col  out  COLS  one-hot column to RAM.
ram_data  out  DW  write data to RAM.
ram_we  out  1  RAM write enable.
ram_led_data  in  DW  RAM combinational read data.

Behaviour:
- Reset values:
  - ram_addr_row = 8'h01, ram_addr_col = 8'h01.
  - ram_data = 0, ram_we = 0.
  - wr_ack = wr_err = 0; rd_valid = 0, rd_data = 0.
  - FSM = IDLE; last_grant = READ.
- All outputs are registered.
- FSM states: IDLE, W_HI, W_LO, W_ACK, R_ADDR, R_ACK, CLR.
- IDLE arbitration:
  - Only wr_req: grant write.
  - Only rd_req: grant read.
  - Both, ARB_RR=1: grant the side opposite last_grant (first contention after reset goes to write).
  - Both, ARB_RR=0: grant write.
  - last_grant updates on every grant.
- Write sequence:
  - Grant → W_HI: ram_we=1, address one-hot encoded from wr_row/wr_col, ram_data=wr_data.
  - W_HI → W_LO: ram_we=0, address and data held.
  - RAM commits on the clock edge ending W_LO.
  - W_LO → W_ACK: wr_ack=1, wr_err=0; then → IDLE.
  - Latency from wr_req sampled in IDLE to wr_ack: 3 cycles.
  - ram_we is never high for 2 consecutive cycles; at least 2 low cycles between write pulses.
- Read sequence:
  - Grant → R_ADDR: address = rd_row/rd_col one-hot, ram_we=0.
  - End of R_ADDR: capture ram_led_data into rd_data.
  - R_ACK: rd_valid=1; then → IDLE.
  - Latency: 2 cycles.
- No grants are made in W_ACK or R_ACK. The requester must drop its req in the ack/valid cycle; a req still high in the following IDLE cycle counts as a new request.
- Mode change:
  - state_d is registered each cycle; toggle = (state != state_d).
  - Toggle in W_HI or W_LO: ram_we forced 0 next cycle, → W_ACK with wr_err=1. The RAM clears, so the pixel is not written.
  - Toggle in R_ADDR: read completes normally; returned data is don't-care.
  - Toggle in IDLE, W_ACK or R_ACK: → CLR (after the ack, if one is pending).
  - CLR lasts exactly 1 cycle with no grant, covering the RAM clear cycle; then → IDLE.
  - A toggle during CLR restarts CLR.
- Simultaneous toggle and new request in IDLE: toggle wins; the request waits.
- Out-of-range indices cannot occur (3-bit fields only).
- Async reset mid-write: ram_we drops to 0 immediately; no ack is issued.

Decomposition:
- Package led_pkg:
  - constants ROWS, COLS, DW;
  - enum arb_state_t {IDLE, W_HI, W_LO, W_ACK, R_ADDR, R_ACK, CLR};
  - function bin_to_onehot (3→8).
- Sub-module led_rr_pick: 2-way round-robin picker (req_w, req_r, last_grant, rr_en → grant_w, grant_r). It is combinational, is instantiated once, and is reused later by the scanner mux.

Test Plan:
- Reset, then wr_req row=2 col=5 data=4'hA → ram_we high exactly 1 cycle with ram_addr_row=8'h04, ram_addr_col=8'h20, ram_data=4'hA; wr_ack at cycle 3, wr_err=0; subsequent read of (2,5) returns 4'hA.
- rd_req row=7 col=0 with RAM model holding 4'h3 → ram_addr_row=8'h80, ram_addr_col=8'h01; rd_valid at cycle 2 with rd_data=4'h3.
- wr_req and rd_req both held continuously, ARB_RR=1 → grants W,R,W,R…, first grant write; with ARB_RR=0 → write granted every time rd_req competes.
- state toggled during W_HI → ram_we 0 next cycle, wr_ack=1 with wr_err=1, then CLR for 1 cycle, then IDLE; the RAM model shows no write to that pixel.
- state toggled in IDLE while rd_req pending → no address change for 1 cycle (CLR); read then granted, rd_valid 3 cycles after the toggle.
- rst_n asserted during W_LO → all outputs at reset values asynchronously; no wr_ack after release.
